mux_nto1_reg: RTL and testbench
===============================

Name: mux_nto1_reg

Overview:
- Parametrised N-to-1 data selector with one output register stage and valid/ready handshakes on every input channel and on the output.
- Operating modes, fixed at elaboration:
  - MODE 0: external select.
  - MODE 1: round-robin arbitration.
- Sits in the datapath where several 32-bit producers share one consumer, e.g. writeback result selection or memory-request funnelling.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (2..16).
- MODE, 0, 0 = external select via sel; 1 = round-robin arbitration, sel ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  $clog2(N)  channel select, MODE 0 only.
- in_valid  in  N  per-channel data valid.
- in_data  in  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept.
- out_valid  out  1  output register holds valid data.
- out_data  out  WIDTH  registered selected data.
- out_src  out  $clog2(N)  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer=0, so channel 0 has highest priority.
- Reset takes effect immediately, mid-transfer included; any held word is discarded. Outputs hold reset values until the first clk edge after rst_n rises.
- load = !out_valid || out_ready.
- Transfer into channel i occurs on a clk edge when in_valid[i] && in_ready[i].
- At most one in_ready bit is high per cycle.
- in_ready is combinational from load, in_valid, sel and the pointer. It never depends on in_data.
- MODE 0:
  - in_ready[i] = load && (sel == i).
  - sel >= N, which is possible when N is not a power of 2, selects nothing: all in_ready=0 and no load.
- MODE 1, grant:
  - grant = first channel with in_valid set, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
  - in_ready[grant] = load. If no channel is valid, no grant.
- MODE 1, pointer update:
  - On a transfer from channel g, ptr <= (g == N-1) ? 0 : g+1.
  - Otherwise ptr holds.
- On a transfer:
  - out_data <= in_data[sel or grant].
  - out_src <= that index.
  - out_valid <= 1.
- No transfer and out_ready && out_valid: out_valid <= 0. out_data and out_src hold their last values.
- Stall, out_valid && !out_ready: out_data, out_src and out_valid hold; all in_ready=0.
- Simultaneous drain and fill, out_valid && out_ready with an input transfer: new word loads in the same cycle. Sustained throughput is 1 word/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- in_valid high with in_ready low: the channel must hold its data. The block never drops or duplicates a word.

Decomposition:
- Shared package mux_pkg:
  - MODE_SEL=0 and MODE_RR=1 constants.
  - Default WIDTH=32.
- One natural sub-module, rr_arbiter: N-bit request vector plus pointer in, one-hot grant and index out. It is instantiated only when MODE==1 (generate).
- The output register and handshake logic stay in mux_nto1_reg.

Test Plan:
- Reset: hold rst_n=0 while driving all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0 throughout. Assert rst_n mid-stall -> out_valid drops to 0 immediately, without waiting for a clk edge.
- MODE 0 pass-through, N=4, out_ready=1:
  - Stimulus: sel=2, in_valid=4'b1111, ch2=32'hDEADBEEF.
  - Response: in_ready=4'b0100; next cycle out_data=32'hDEADBEEF, out_src=2, out_valid=1.
  - Then sel=0, ch0=32'h1 -> next cycle out_data=1, out_src=0, with no idle bubble.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with sel=1 and in_valid[1]=1 -> in_ready=0, out_data unchanged. Raise out_ready -> ch1 loads the following cycle.
- MODE 1 fairness, N=4, in_valid=4'b1111 constant, out_ready=1 -> out_src sequence 0,1,2,3,0,1.
- MODE 1 skip and wrap: in_valid=4'b1001 -> out_src alternates 0,3,0,3. With pointer=3 and only ch1 valid -> ch1 is granted (wrap), pointer becomes 2.
- MODE 0 out-of-range select, N=3: sel=3 with all in_valid=1 -> in_ready=0, out_valid deasserts after the current word drains.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the registered N-to-1 selector family.
package mux_pkg;
   localparam int MODE_SEL      = 0;
   localparam int MODE_RR       = 1;
   localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority grant; the request at or above i_ptr wins first, else the lowest below it.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic [N-1:0]         o_gnt,
   output logic [$clog2(N)-1:0] o_idx
);
   localparam int IW = $clog2(N);
   logic          w_hi_any;
   logic          w_lo_any;
   logic [IW-1:0] w_hi;
   logic [IW-1:0] w_lo;
   // Scanning downward leaves the lowest matching index in each candidate.
   always_comb begin
      w_hi_any = 1'b0;
      w_lo_any = 1'b0;
      w_hi     = '0;
      w_lo     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            w_lo     = IW'(i);
            w_lo_any = 1'b1;
         end
         if (i_req[i] && IW'(i) >= i_ptr) begin
            w_hi     = IW'(i);
            w_hi_any = 1'b1;
         end
      end
   end
   assign o_idx = w_hi_any ? w_hi : w_lo;
   assign o_gnt = (w_hi_any || w_lo_any) ? N'(1) << o_idx : '0;
endmodule

// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: N-to-1 data selector with one output register and valid/ready on every channel.
module mux_nto1_reg
   import mux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = 4,
   parameter int MODE  = MODE_SEL
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [$clog2(N)-1:0]   sel,
   input  logic [N-1:0]           in_valid,
   input  logic [N*WIDTH-1:0]     in_data,
   output logic [N-1:0]           in_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic [$clog2(N)-1:0]   out_src,
   input  logic                   out_ready
);
   localparam int IW = $clog2(N);
   logic             w_load;
   logic             w_xfer;
   logic [N-1:0]     w_ready;
   logic [IW-1:0]    w_idx;
   logic [WIDTH-1:0] w_ch [N];
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [IW-1:0]    r_src;

   // Gating with rst_n keeps every in_ready low while reset is held.
   assign w_load = rst_n && (!r_valid || out_ready);
   assign w_xfer = |(w_ready & in_valid);

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
   end

   if (MODE == MODE_RR) begin : g_rr
      logic [IW-1:0] r_ptr;
      logic [N-1:0]  w_gnt;
      logic          w_unused_sel;
      rr_arbiter #(.N(N)) u_arb (
         .i_req (in_valid),
         .i_ptr (r_ptr),
         .o_gnt (w_gnt),
         .o_idx (w_idx)
      );
      assign w_ready      = w_load ? w_gnt : '0;
      assign w_unused_sel = ^sel;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            r_ptr <= '0;
         else if (w_xfer)
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
      end
   end else begin : g_sel
      logic w_hit;
      // sel values past N-1 exist when N is not a power of two; they select nothing.
      assign w_hit   = {1'b0, sel} < (IW + 1)'(N);
      assign w_idx   = sel;
      assign w_ready = (w_load && w_hit) ? N'(1) << sel : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_ch[w_idx];
         r_src   <= w_idx;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign in_ready  = w_ready;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_src   = r_src;
endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb_mux_nto1_reg: directed and randomized checks of external-select (N=4, N=3) and round-robin (N=4) builds.
module tb_mux_nto1_reg;
   import mux_pkg::*;
   localparam int W = 32;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;

   logic [1:0]     a_sel = '0, b_sel = '0, c_sel = '0;
   logic [3:0]     a_iv = '0, a_ir, b_iv = '0, b_ir;
   logic [2:0]     c_iv = '0, c_ir;
   logic [4*W-1:0] a_id = '0, b_id = '0;
   logic [3*W-1:0] c_id = '0;
   logic           a_ov, b_ov, c_ov;
   logic           a_or = 1'b0, b_or = 1'b0, c_or = 1'b0;
   logic [W-1:0]   a_od, b_od, c_od;
   logic [1:0]     a_os, b_os, c_os;

   mux_nto1_reg #(.WIDTH(W), .N(4), .MODE(MODE_SEL)) u_a (
      .clk(clk), .rst_n(rst_n), .sel(a_sel), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
      .out_valid(a_ov), .out_data(a_od), .out_src(a_os), .out_ready(a_or));
   mux_nto1_reg #(.WIDTH(W), .N(4), .MODE(MODE_RR)) u_b (
      .clk(clk), .rst_n(rst_n), .sel(b_sel), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
      .out_valid(b_ov), .out_data(b_od), .out_src(b_os), .out_ready(b_or));
   mux_nto1_reg #(.WIDTH(W), .N(3), .MODE(MODE_SEL)) u_c (
      .clk(clk), .rst_n(rst_n), .sel(c_sel), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
      .out_valid(c_ov), .out_data(c_od), .out_src(c_os), .out_ready(c_or));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      rst_n = 1'b0;
      a_iv = '1; b_iv = '1; c_iv = '1;
      a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
      a_id = {4{32'h1234_5678}}; b_id = {4{32'h9ABC_DEF0}}; c_id = {3{32'h0F0F_0F0F}};
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if ({a_ov, a_od, a_os, a_ir} !== '0) begin
            failures++;
            $display("FAIL reset_a cyc=%0d got ov=%b od=%h os=%0d ir=%b exp all zero", k, a_ov, a_od, a_os, a_ir);
         end
         checks++;
         if ({b_ov, b_od, b_os, b_ir} !== '0) begin
            failures++;
            $display("FAIL reset_b cyc=%0d got ov=%b od=%h os=%0d ir=%b exp all zero", k, b_ov, b_od, b_os, b_ir);
         end
         checks++;
         if ({c_ov, c_od, c_os, c_ir} !== '0) begin
            failures++;
            $display("FAIL reset_c cyc=%0d got ov=%b od=%h os=%0d ir=%b exp all zero", k, c_ov, c_od, c_os, c_ir);
         end
         tick();
      end
      a_iv = '0; b_iv = '0; c_iv = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_passthrough();
      a_or = 1'b1; a_sel = 2'd2; a_iv = 4'b1111;
      a_id = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
      #1;
      checks++;
      if (a_ir !== 4'b0100) begin
         failures++;
         $display("FAIL pass_ready got=%b exp=0100", a_ir);
      end
      tick();
      checks++;
      if ({a_ov, a_od, a_os} !== {1'b1, 32'hDEAD_BEEF, 2'd2}) begin
         failures++;
         $display("FAIL pass_out1 got ov=%b od=%h os=%0d exp ov=1 od=deadbeef os=2", a_ov, a_od, a_os);
      end
      a_sel = 2'd0;
      a_id[31:0] = 32'h1;
      #1;
      checks++;
      if (a_ir !== 4'b0001) begin
         failures++;
         $display("FAIL pass_ready2 got=%b exp=0001", a_ir);
      end
      tick();
      checks++;
      if ({a_ov, a_od, a_os} !== {1'b1, 32'h1, 2'd0}) begin
         failures++;
         $display("FAIL pass_out2 got ov=%b od=%h os=%0d exp ov=1 od=1 os=0", a_ov, a_od, a_os);
      end
   endtask

   task automatic test_backpressure();
      a_or = 1'b0; a_sel = 2'd1; a_iv = 4'b0010;
      a_id[63:32] = 32'hCAFE_0001;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (a_ir !== 4'b0000) begin
            failures++;
            $display("FAIL bp_ready cyc=%0d got=%b exp=0000", k, a_ir);
         end
         tick();
         checks++;
         if ({a_ov, a_od, a_os} !== {1'b1, 32'h1, 2'd0}) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got ov=%b od=%h os=%0d exp ov=1 od=1 os=0", k, a_ov, a_od, a_os);
         end
      end
      a_or = 1'b1;
      #1;
      checks++;
      if (a_ir !== 4'b0010) begin
         failures++;
         $display("FAIL bp_release got=%b exp=0010", a_ir);
      end
      tick();
      checks++;
      if ({a_ov, a_od, a_os} !== {1'b1, 32'hCAFE_0001, 2'd1}) begin
         failures++;
         $display("FAIL bp_load got ov=%b od=%h os=%0d exp ov=1 od=cafe0001 os=1", a_ov, a_od, a_os);
      end
      a_iv = '0;
      tick();
      checks++;
      if (a_ov !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain got ov=%b exp=0", a_ov);
      end
   endtask

   task automatic test_async_reset();
      a_or = 1'b0; a_sel = 2'd0; a_iv = 4'b0001;
      a_id[31:0] = 32'h55;
      tick();
      a_iv = '0;
      tick();
      checks++;
      if ({a_ov, a_od} !== {1'b1, 32'h55}) begin
         failures++;
         $display("FAIL areset_pre got ov=%b od=%h exp ov=1 od=55", a_ov, a_od);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_ov, a_od, a_os} !== '0) begin
         failures++;
         $display("FAIL areset_now got ov=%b od=%h os=%0d exp all zero", a_ov, a_od, a_os);
      end
      tick();
      rst_n = 1'b1;
      a_or = 1'b1;
   endtask

   task automatic test_rr_fairness();
      int exp_src [6] = '{0, 1, 2, 3, 0, 1};
      b_or = 1'b1; b_iv = 4'b1111;
      for (int i = 0; i < 4; i++) b_id[i*W +: W] = 32'd100 + 32'(i);
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if ({b_ov, b_os, b_od} !== {1'b1, 2'(exp_src[k]), 32'd100 + 32'(exp_src[k])}) begin
            failures++;
            $display("FAIL rr_fair step=%0d got ov=%b os=%0d od=%0d exp os=%0d", k, b_ov, b_os, b_od, exp_src[k]);
         end
      end
   endtask

   task automatic test_rr_wrap();
      int exp_src [4] = '{3, 0, 3, 0};
      b_iv = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (b_os !== 2'(exp_src[k])) begin
            failures++;
            $display("FAIL rr_skip step=%0d got os=%0d exp=%0d", k, b_os, exp_src[k]);
         end
      end
      b_iv = 4'b0100;
      tick();
      b_iv = 4'b0010;
      #1;
      checks++;
      if (b_ir !== 4'b0010) begin
         failures++;
         $display("FAIL rr_wrap_ready got=%b exp=0010", b_ir);
      end
      tick();
      checks++;
      if (b_os !== 2'd1) begin
         failures++;
         $display("FAIL rr_wrap got os=%0d exp=1", b_os);
      end
      b_iv = 4'b1111;
      tick();
      checks++;
      if (b_os !== 2'd2) begin
         failures++;
         $display("FAIL rr_ptr_after_wrap got os=%0d exp=2", b_os);
      end
      b_iv = '0;
   endtask

   task automatic test_out_of_range();
      c_or = 1'b1; c_sel = 2'd0; c_iv = 3'b111;
      c_id = {32'hC2, 32'hC1, 32'hC0};
      #1;
      checks++;
      if (c_ir !== 3'b001) begin
         failures++;
         $display("FAIL oor_ready0 got=%b exp=001", c_ir);
      end
      tick();
      c_sel = 2'd3;
      #1;
      checks++;
      if (c_ir !== 3'b000) begin
         failures++;
         $display("FAIL oor_ready3 got=%b exp=000", c_ir);
      end
      tick();
      checks++;
      if ({c_ov, c_od, c_os} !== {1'b0, 32'hC0, 2'd0}) begin
         failures++;
         $display("FAIL oor_drain got ov=%b od=%h os=%0d exp ov=0 od=c0 os=0", c_ov, c_od, c_os);
      end
      tick();
      checks++;
      if (c_ov !== 1'b0) begin
         failures++;
         $display("FAIL oor_idle got ov=%b exp=0", c_ov);
      end
      c_iv = '0;
   endtask

   // Reference: a single held word plus a priority pointer, evaluated with modular arithmetic.
   task automatic test_random(input bit rr);
      logic [3:0]   v = '0, pend = '0, exp_rdy, rdy;
      logic [W-1:0] d [4] = '{default: '0};
      logic [1:0]   s;
      bit           o, ld, xfer;
      bit           m_v = 1'b0;
      logic [W-1:0] m_d = '0;
      int           m_s = 0, m_p = 0, g;
      do_reset();
      for (int t = 0; t < 300; t++) begin
         for (int i = 0; i < 4; i++) begin
            v[i] = pend[i] ? 1'b1 : 1'($urandom_range(0, 1));
            if (!pend[i]) d[i] = $urandom;
         end
         s = 2'($urandom_range(0, 3));
         o = $urandom_range(0, 3) != 0;
         if (rr) begin
            b_iv = v; b_or = o;
            for (int i = 0; i < 4; i++) b_id[i*W +: W] = d[i];
         end else begin
            a_iv = v; a_sel = s; a_or = o;
            for (int i = 0; i < 4; i++) a_id[i*W +: W] = d[i];
         end
         #1;
         ld = !m_v || o;
         g = -1;
         if (ld && !rr) g = int'(s);
         if (ld && rr)
            for (int k = 3; k >= 0; k--)
               if (v[(m_p + k) % 4]) g = (m_p + k) % 4;
         exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
         xfer = (g >= 0) && v[g];
         rdy = rr ? b_ir : a_ir;
         checks++;
         if (rdy !== exp_rdy) begin
            failures++;
            $display("FAIL rand_ready rr=%0d t=%0d got=%b exp=%b", rr, t, rdy, exp_rdy);
         end
         tick();
         if (xfer) begin
            m_v = 1'b1; m_d = d[g]; m_s = g; m_p = (g + 1) % 4;
         end else if (o) begin
            m_v = 1'b0;
         end
         pend = v & ~(xfer ? 4'(1 << g) : 4'b0);
         checks++;
         if ((rr ? b_ov : a_ov) !== m_v) begin
            failures++;
            $display("FAIL rand_valid rr=%0d t=%0d got=%b exp=%b", rr, t, rr ? b_ov : a_ov, m_v);
         end
         checks++;
         if ((rr ? b_od : a_od) !== m_d) begin
            failures++;
            $display("FAIL rand_data rr=%0d t=%0d got=%h exp=%h", rr, t, rr ? b_od : a_od, m_d);
         end
         checks++;
         if ((rr ? b_os : a_os) !== 2'(m_s)) begin
            failures++;
            $display("FAIL rand_src rr=%0d t=%0d got=%0d exp=%0d", rr, t, rr ? b_os : a_os, m_s);
         end
      end
      a_iv = '0; b_iv = '0;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_backpressure();
      test_async_reset();
      test_rr_fairness();
      test_rr_wrap();
      test_out_of_range();
      test_random(1'b0);
      test_random(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
